// File: rtl/bus_sequencer_if.sv
// Single-beat Wishbone-style bus between the sequencer and the system.
// The master side drives the cycle; the slave side answers it.
interface bus_sequencer_if;
    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [29:0] adr_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        ack_i;
    logic        err_i;

    modport master (
        output cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
        input  dat_i, ack_i, err_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
        output dat_i, ack_i, err_i
    );
endinterface

// File: rtl/bus_sequencer.sv
// Two-port (fetch/data) bus master: round-robin grant, one single-beat
// cycle per request, byte-lane select and data steering for sub-word access.
module bus_sequencer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        i_req,
    input  logic [31:0] i_adr,
    output logic        i_ack,
    output logic        i_err,
    output logic [31:0] i_dat,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_adr,
    input  logic [31:0] d_wdat,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] d_rdat,
    bus_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        last_d_q, last_d_d;
    logic        gnt_d_q, gnt_d_d;
    logic        err_q, err_d;
    logic        we_q, we_d;
    logic [29:0] adr_q, adr_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] dat_q, dat_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  lane_q, lane_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] idat_q, idat_d;
    logic [31:0] rdat_q, rdat_d;

    logic        pick_d;
    logic        c_we;
    logic [1:0]  c_size;
    logic [31:0] c_adr;
    logic [31:0] c_wdat;
    logic [1:0]  a;
    logic        legal;
    logic [3:0]  c_sel;
    logic [31:0] c_dat;
    logic [31:0] byte_rd;
    logic [31:0] r_dat;

    // Data wins a tie unless it was the most recent grant.
    always_comb begin
        pick_d = d_req && (!i_req || !last_d_q);
        c_we   = pick_d && d_we;
        c_size = pick_d ? d_size : 2'b10;
        c_adr  = pick_d ? d_adr : i_adr;
        c_wdat = pick_d ? d_wdat : 32'h0;
        a      = c_adr[1:0];
    end

    always_comb begin
        legal = 1'b0;
        c_sel = 4'b1111;
        c_dat = c_wdat;
        unique case (1'b1)
            c_size == 2'b00: begin
                legal = 1'b1;
                c_sel = 4'b0001 << a;
                c_dat = {24'h0, c_wdat[7:0]} << {a, 3'b000};
            end
            c_size == 2'b01: begin
                legal = !a[0];
                c_sel = a[1] ? 4'b1100 : 4'b0011;
                c_dat = a[1] ? {c_wdat[15:0], 16'h0}
                             : {16'h0, c_wdat[15:0]};
            end
            c_size == 2'b10: begin
                legal = (a == 2'b00);
            end
            default: begin
                legal = 1'b0;
            end
        endcase
        if (!c_we) c_dat = 32'h0;
    end

    always_comb begin
        byte_rd = bus.dat_i >> {lane_q, 3'b000};
        r_dat   = bus.dat_i;
        unique case (1'b1)
            size_q == 2'b00: r_dat = {24'h0, byte_rd[7:0]};
            size_q == 2'b01: r_dat = lane_q[1] ? {16'h0, bus.dat_i[31:16]}
                                               : {16'h0, bus.dat_i[15:0]};
            default:         r_dat = bus.dat_i;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        gnt_d_d  = gnt_d_q;
        err_d    = err_q;
        we_d     = we_q;
        adr_d    = adr_q;
        sel_d    = sel_q;
        dat_d    = dat_q;
        size_d   = size_q;
        lane_d   = lane_q;
        cnt_d    = cnt_q;
        idat_d   = idat_q;
        rdat_d   = rdat_q;
        unique case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    last_d_d = pick_d;
                    gnt_d_d  = pick_d;
                    if (legal) begin
                        state_d = BUS;
                        err_d   = 1'b0;
                        we_d    = c_we;
                        adr_d   = c_adr[31:2];
                        sel_d   = c_sel;
                        dat_d   = c_dat;
                        size_d  = c_size;
                        lane_d  = a;
                        cnt_d   = 8'h0;
                    end else begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end
                end
            end
            BUS: begin
                cnt_d = cnt_q + 8'd1;
                if (bus.err_i) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end else if (bus.ack_i) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    if (!we_q) begin
                        if (gnt_d_q) rdat_d = r_dat;
                        else         idat_d = r_dat;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            gnt_d_q  <= 1'b0;
            err_q    <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= 30'h0;
            sel_q    <= 4'h0;
            dat_q    <= 32'h0;
            size_q   <= 2'b00;
            lane_q   <= 2'b00;
            cnt_q    <= 8'h0;
            idat_q   <= 32'h0;
            rdat_q   <= 32'h0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            gnt_d_q  <= gnt_d_d;
            err_q    <= err_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            sel_q    <= sel_d;
            dat_q    <= dat_d;
            size_q   <= size_d;
            lane_q   <= lane_d;
            cnt_q    <= cnt_d;
            idat_q   <= idat_d;
            rdat_q   <= rdat_d;
        end
    end

    // Cycle strobes come straight from the state flop so reset drops them at once.
    assign bus.cyc_o = (state_q == BUS);
    assign bus.stb_o = (state_q == BUS);
    assign bus.we_o  = we_q;
    assign bus.adr_o = adr_q;
    assign bus.sel_o = sel_q;
    assign bus.dat_o = dat_q;

    assign i_ack  = (state_q == RESP) && !gnt_d_q && !err_q;
    assign i_err  = (state_q == RESP) && !gnt_d_q && err_q;
    assign d_ack  = (state_q == RESP) && gnt_d_q && !err_q;
    assign d_err  = (state_q == RESP) && gnt_d_q && err_q;
    assign i_dat  = idat_q;
    assign d_rdat = rdat_q;
endmodule

// File: doc/bus_sequencer.md
Name: bus_sequencer

Overview:
Two-port bus master for the CPU. It arbitrates between the instruction-fetch port and the data port, then runs one single-beat Wishbone-style cycle per request. For each cycle it derives the byte-select from the address and access size and steers write and read data across the byte lanes. It sits between the CPU core and the system bus and owns the lane-steering and access-sequencing function for all sub-word accesses.

Parameters:
TIMEOUT, 255, number of cycles spent in BUS without ack_i/err_i before the access is aborted with an error (8-bit counter; legal range 1..255)

Ports:
clk_i  in  1  system clock; all state updates on the rising edge
rst_i  in  1  reset, asynchronous, active-high
i_req  in  1  fetch request; held with i_adr until i_ack or i_err
i_adr  in  32  fetch byte address; always a 32-bit word read
i_ack  out  1  one-cycle pulse: fetch complete, i_dat valid
i_err  out  1  one-cycle pulse: fetch failed (bus error, timeout, misaligned)
i_dat  out  32  fetch read data; holds until the next fetch completes
d_req  in  1  data request; held with all d_* inputs until d_ack or d_err
d_we  in  1  1 = write, 0 = read
d_size  in  2  access size: 00 = byte, 01 = halfword, 10 = word, 11 = illegal
d_adr  in  32  data byte address
d_wdat  in  32  write data, right-justified
d_ack  out  1  one-cycle pulse: data access complete
d_err  out  1  one-cycle pulse: data access failed
d_rdat  out  32  read data, right-justified and zero-extended
cyc_o  out  1  bus cycle active
stb_o  out  1  strobe; always equal to cyc_o
we_o  out  1  bus write enable
adr_o  out  30  bus word address (byte address bits [31:2])
sel_o  out  4  byte lane enables
dat_o  out  32  bus write data
dat_i  in  32  bus read data
ack_i  in  1  bus acknowledge
err_i  in  1  bus error

Behaviour:
- Reset values: all outputs 0, state IDLE, last-grant = fetch, timeout counter 0. Asserting rst_i mid-cycle drops cyc_o/stb_o immediately (asynchronous). No ack or err is issued for the aborted access.
- States:
  - IDLE: with no request pending, remain in IDLE.
  - IDLE, grant to a legal access: latch the requester's fields, register cyc_o, stb_o, we_o, adr_o, sel_o, dat_o, clear the counter, go to BUS.
  - IDLE, grant to an illegal access: go straight to RESP with err set. No bus cycle is issued.
  - BUS: cyc_o = stb_o = 1; we_o, adr_o, sel_o and dat_o are stable throughout.
  - BUS, ack_i = 1: capture the steered dat_i, drop cyc_o/stb_o, go to RESP (ok).
  - BUS, err_i = 1: drop cyc_o/stb_o, go to RESP (err). If ack_i and err_i are high together, err wins.
  - BUS, timeout: the counter increments every BUS cycle. When it reaches TIMEOUT, drop cyc_o/stb_o and go to RESP (err).
  - RESP: pulse exactly one of the granted port's ack/err for one cycle, then return to IDLE.
- Latency: request first seen in IDLE at cycle N → cyc_o = 1 at N+1. ack_i sampled at cycle M → port ack at M+1 with data already valid. The earliest next grant is M+2. A zero-wait-state bus gives 3 cycles per access.
- Arbitration (in IDLE only):
  - A single requester is granted.
  - If both request, grant the port not granted last (round-robin). Last-grant updates on every grant, including misaligned grants.
- Select and steering, using a = adr[1:0]:
  - Word: a must be 00; sel = 1111; dat_o = wdat; rdat = dat_i.
  - Halfword: a = 00 → sel 0011, data on [15:0]. a = 10 → sel 1100, dat_o = {wdat[15:0], 16'h0}, rdat = {16'h0, dat_i[31:16]}. a[0] = 1 is illegal.
  - Byte: a = 00/01/10/11 → sel 0001/0010/0100/1000. wdat[7:0] is placed on lane a with the other lanes 0. rdat = {24'h0, dat_i lane a}.
  - Illegal accesses: d_size = 11, a misaligned halfword, or a misaligned word. Fetch is always a word access, so i_adr[1:0] ≠ 00 is an illegal fetch.
- For reads, dat_o = 0 and we_o = 0.
- i_dat/d_rdat update only on a successful read for that port. On any error the previous value is kept.
- Requesters must deassert req in the cycle after they receive ack/err. A req still high in IDLE is treated as a new request.

Test Plan:
1. Byte writes: d_size = 00, d_we = 1, d_wdat = 0x000000A5 at addresses 0x100..0x103 → sel_o = 0001/0010/0100/1000; dat_o = 0x000000A5, 0x0000A500, 0x00A50000, 0xA5000000; adr_o = 0x40; one d_ack per access.
2. Halfword read: d_adr = 0x202, dat_i = 0xBEEF1234 → sel_o = 1100, d_rdat = 0x0000BEEF. Zero-wait ack gives cyc_o high for exactly 1 cycle and d_ack 2 cycles after the request is sampled.
3. Contention: i_req and d_req held high from reset for 4 accesses → grant order fetch-less-recent alternates D, I, D, I (last-grant resets to fetch, so data wins first).
4. Misaligned access: d_size = 01 with d_adr = 0x301, and i_adr = 0x002 → d_err / i_err pulses, cyc_o never asserts, and d_rdat/i_dat are unchanged.
5. Bus faults:
   - TIMEOUT = 4 with ack_i held low → cyc_o high exactly 4 cycles, then d_err.
   - err_i together with ack_i → err only.
6. Reset mid-access: assert rst_i while in BUS → cyc_o = 0 before the next clock edge, no ack/err issued, and the next access proceeds normally.
